// File: rtl/dff_rise_capture_pkg.sv
// Shared constants for the rising-edge capture register slice.
// Provides the all-ones source used to build the default INIT value.
package dff_rise_capture_pkg;

    localparam int unsigned MAX_WIDTH = 256;

    // Sliced to WIDTH by users to form an all-ones default of any supported width.
    localparam logic [MAX_WIDTH-1:0] ALL_ONES = '1;

endpackage

// File: rtl/dff_rise_capture_bit.sv
// Single storage bit: rising-edge capture with synchronous active-high reset to INIT.
// Power-up value equals INIT so the output is defined before the first edge.
module dff_rise_bit #(
    parameter logic INIT = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic q_q = INIT;
    logic q_d;

    // Reset wins over data; X on d passes straight through to q_q.
    always_comb begin
        q_d = d;
        if (rst) begin
            q_d = INIT;
        end
    end

    always_ff @(posedge clk) begin
        q_q <= q_d;
    end

    assign q = q_q;

endmodule

// File: rtl/dff_rise_capture.sv
// WIDTH independent rising-edge flops with synchronous reset to INIT.
// qb is the combinational complement of the assembled q vector.
module dff_rise_capture
    import dff_rise_capture_pkg::*;
#(
    parameter int unsigned      WIDTH = 1,
    parameter logic [WIDTH-1:0] INIT  = ALL_ONES[WIDTH-1:0]
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qb
);

    logic [WIDTH-1:0] q_bits;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        dff_rise_bit #(
            .INIT (INIT[i])
        ) u_bit (
            .clk (clk),
            .rst (rst),
            .d   (d[i]),
            .q   (q_bits[i])
        );
    end

    assign q  = q_bits;
    assign qb = ~q_bits;

endmodule

// File: tb/tb_dff_rise_capture.sv
// Directed bench for dff_rise_capture: default 1-bit instance and a 4-bit instance
// with INIT=1010, sharing a hand-driven clock; expectations flow through a scoreboard queue.
module tb_dff_rise_capture;

    typedef struct {
        string    name;
        bit       sel;    // 0: 1-bit default instance, 1: 4-bit instance
        logic [3:0] q;
        logic [3:0] qb;
    } exp_t;

    logic       clk;
    logic       rst_a;
    logic [0:0] d_a;
    logic [0:0] q_a;
    logic [0:0] qb_a;
    logic       rst_b;
    logic [3:0] d_b;
    logic [3:0] q_b;
    logic [3:0] qb_b;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    dff_rise_capture u_dut_a (
        .clk (clk),
        .rst (rst_a),
        .d   (d_a),
        .q   (q_a),
        .qb  (qb_a)
    );

    dff_rise_capture #(
        .WIDTH (4),
        .INIT  (4'b1010)
    ) u_dut_b (
        .clk (clk),
        .rst (rst_b),
        .d   (d_b),
        .q   (q_b),
        .qb  (qb_b)
    );

    task automatic clk_to(input logic v);
        clk = v;
        #2;
    endtask

    task automatic set_da(input logic v);
        d_a = v;
        #2;
    endtask

    task automatic expect_a(input string name, input logic qv);
        exp_t e;
        e.name = name;
        e.sel  = 1'b0;
        e.q    = {3'b000, qv};
        e.qb   = {3'b000, ~qv};
        exp_q.push_back(e);
        #1;
    endtask

    task automatic expect_b(input string name, input logic [3:0] qv, input logic [3:0] qbv);
        exp_t e;
        e.name = name;
        e.sel  = 1'b1;
        e.q    = qv;
        e.qb   = qbv;
        exp_q.push_back(e);
        #1;
    endtask

    // Monitor: compares each expectation against the live outputs as soon as it is queued.
    initial begin
        exp_t e;
        forever begin
            wait (exp_q.size() != 0);
            e = exp_q.pop_front();
            total++;
            if (e.sel == 1'b0) begin
                if (q_a[0] !== e.q[0] || qb_a[0] !== e.qb[0]) begin
                    bad++;
                    $display("FAIL %s: q=%b qb=%b, required q=%b qb=%b",
                             e.name, q_a[0], qb_a[0], e.q[0], e.qb[0]);
                end
            end else begin
                if (q_b !== e.q || qb_b !== e.qb) begin
                    bad++;
                    $display("FAIL %s: q=%b qb=%b, required q=%b qb=%b",
                             e.name, q_b, qb_b, e.q, e.qb);
                end
            end
        end
    end

    initial begin
        logic [3:0] toggles;
        clk   = 1'b0;
        rst_a = 1'b0;
        rst_b = 1'b0;
        d_a   = 1'b0;
        d_b   = 4'b1010;
        #1;

        // Power-up values, no edge yet
        expect_a("powerup_a", 1'b1);
        expect_b("powerup_b", 4'b1010, 4'b0101);

        // clk low, d toggling: INIT must hold
        toggles = 4'b1010;
        for (int i = 0; i < 4; i++) begin
            set_da(toggles[i]);
            expect_a("clk_low_hold", 1'b1);
        end

        // d=0 captured on rising edge
        set_da(1'b0);
        clk_to(1'b1);
        expect_a("rise_capture_0", 1'b0);

        // clk high, d toggling: q keeps 0
        for (int i = 0; i < 4; i++) begin
            set_da(toggles[3-i]);
            expect_a("clk_high_hold", 1'b0);
        end

        // d=1 then falling edge: hold; next rising edge captures 1
        set_da(1'b1);
        clk_to(1'b0);
        expect_a("fall_hold", 1'b0);
        clk_to(1'b1);
        expect_a("rise_capture_1", 1'b1);

        // Two consecutive edges with d=1, then d=0
        clk_to(1'b0);
        clk_to(1'b1);
        expect_a("repeat_edge_stable", 1'b1);
        clk_to(1'b0);
        set_da(1'b0);
        clk_to(1'b1);
        expect_a("rise_capture_0_again", 1'b0);

        // Reset asserted between edges takes effect only at the next rising edge
        rst_a = 1'b1;
        #2;
        expect_a("rst_wait_edge_high", 1'b0);
        clk_to(1'b0);
        expect_a("rst_wait_edge_low", 1'b0);
        clk_to(1'b1);
        expect_a("rst_loads_init", 1'b1);
        rst_a = 1'b0;
        clk_to(1'b0);
        clk_to(1'b1);
        expect_a("post_rst_capture", 1'b0);

        // Instance B held 1010 throughout; now wide capture and reset
        expect_b("b_hold_before", 4'b1010, 4'b0101);
        clk_to(1'b0);
        d_b = 4'b0110;
        #2;
        clk_to(1'b1);
        expect_b("b_capture_0110", 4'b0110, 4'b1001);
        clk_to(1'b0);
        d_b = 4'b0101;
        rst_b = 1'b1;
        #2;
        expect_b("b_rst_pending", 4'b0110, 4'b1001);
        clk_to(1'b1);
        expect_b("b_rst_init", 4'b1010, 4'b0101);
        clk_to(1'b0);
        rst_b = 1'b0;
        #2;
        clk_to(1'b1);
        expect_b("b_bits_independent", 4'b0101, 4'b1010);

        #5;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain: pending=%0d, required 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dff_rise_capture.md
DFF_RISE_CAPTURE -- requirements
Module: dff_rise_capture

Interface
REQ-001 Parameter WIDTH, default 1, number of independent storage bits.
REQ-002 Parameter INIT, default all-ones of WIDTH bits, value loaded at reset and at power-up.
REQ-003 Port clk  input  1  single clock; all state updates on its rising edge only.
REQ-004 Port rst  input  1  synchronous, active-high reset, sampled on rising clk edge.
REQ-005 Port d  input  WIDTH  data captured on the rising clk edge.
REQ-006 Port q  output  WIDTH  registered data.
REQ-007 Port qb  output  WIDTH  bitwise complement of q.
REQ-008 The block SHALL have one clock and a synchronous active-high reset, with clock port clk and reset port rst; polarity and synchronicity are fixed.

Function
REQ-009 On a rising clk edge with rst=0, q SHALL take the value of d present at that edge, with zero added cycles of latency (visible immediately after the edge).
REQ-010 On a falling clk edge, q SHALL hold.
REQ-011 While clk is stable, high or low, any change of d SHALL leave q unchanged.
REQ-012 qb SHALL equal ~q at all times and be combinationally derived from q, not separately registered.
REQ-013 Each bit SHALL be independent; no cross-bit interaction.
REQ-014 An unknown or X d bit at a rising edge SHALL propagate as unknown into the corresponding q bit; no sanitising.
REQ-015 Repeated rising edges with unchanged d SHALL leave q unchanged and produce no glitch on q or qb.
REQ-016 The block SHALL have no enable, no asynchronous inputs and no internal state other than the WIDTH storage bits.
REQ-017 No timing delays SHALL be modelled in RTL; output buffering and inversion delays belong to the physical implementation.

Reset
REQ-018 Power-up or initial value of q SHALL be INIT, so q=1 and qb=0 for default parameters before any clock edge.
REQ-019 On a rising clk edge with rst=1, q SHALL load INIT, taking priority over d.
REQ-020 Reset asserted mid-operation SHALL take effect at the next rising edge only; q SHALL hold between edges.
REQ-021 After rst deasserts, the first rising edge SHALL capture d normally.

Structure
REQ-022 A shared package SHALL hold the default-INIT helper constant (all-ones for a given width); no typedefs are required.
REQ-023 A single-bit sub-module dff_rise_bit, carrying clk, rst, d, q and a 1-bit init parameter, SHALL be instantiated WIDTH times via generate.
REQ-024 qb SHALL be produced in the top-level by inversion of the assembled q vector.

Verification
REQ-025 No clock edge, d toggled 0,1,0,1 with clk=0 -> q=1 and qb=0 throughout, holding the INIT value.
REQ-026 clk held 1, d toggled 0,1,0,1 -> q remains at its pre-existing value.
REQ-027 d=0, then clk 0->1 -> q=0 and qb=1 right after the edge; d=1, then clk 1->0 -> q stays 0; next clk 0->1 -> q=1.
REQ-028 d=1 across two consecutive rising edges -> q stays 1 with no transition; then d=0 and a rising edge -> q=0.
REQ-029 q=0, rst=1 at a rising edge with d=0 -> q=1; rst=0 with d=0 at the next edge -> q=0.
REQ-030 WIDTH=4, INIT=4'b1010, d=4'b0110 at a rising edge -> q=0110 and qb=1001; rst at the next edge -> q=1010.
